// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 4-register / ALU datapath.
// A small FIFO queues instructions, and each one is issued as an EXEC cycle followed by a WRITE cycle.
module datapath_sequencer #(
  parameter int FIFO_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   InstrValid,
  input  logic [9:0]             InstrData,
  output logic                   InstrReady,
  output logic [1:0]             RegReadAddr1,
  output logic [1:0]             RegReadAddr2,
  output logic [1:0]             RegWriteAddr,
  output logic                   RegWriteEnable,
  output logic [2:0]             ALUControl,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] RetiredCount
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;

  state_e                 state_q, state_d;
  logic [9:0]             ir_q, ir_d;
  logic [9:0]             fifo_q [FIFO_DEPTH];
  logic [9:0]             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   push, pop;

  assign InstrReady   = (count_q != CNT_W'(FIFO_DEPTH));
  assign Busy         = (state_q != IDLE) || (count_q != '0);
  assign RetiredCount = retired_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    retired_d = retired_q;
    push      = InstrValid && InstrReady;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          ir_d    = fifo_q[rd_ptr_q];
          state_d = EXEC;
        end
      end
      EXEC: state_d = WRITE;
      WRITE: begin
        retired_d = retired_q + COUNT_WIDTH'(1);
        if (count_q != '0) begin
          pop     = 1'b1;
          ir_d    = fifo_q[rd_ptr_q];
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = InstrData;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    RegReadAddr1   = 2'b00;
    RegReadAddr2   = 2'b00;
    RegWriteAddr   = 2'b00;
    ALUControl     = 3'b000;
    RegWriteEnable = 1'b0;
    if (state_q == EXEC || state_q == WRITE) begin
      RegReadAddr1 = ir_q[3:2];
      RegReadAddr2 = ir_q[1:0];
      RegWriteAddr = ir_q[5:4];
      ALUControl   = ir_q[8:6];
    end
    // A low Rst masks the write strobe so a reset cycle can never commit a write.
    if (state_q == WRITE) begin
      RegWriteEnable = ~ir_q[9] & Rst;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge Clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a cycle-by-cycle vector table on the default build,
// followed by a counter-wrap sequence on a second instance built with a 2-bit retire counter.
module tb_datapath_sequencer;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [9:0]  data;
    logic        chk;
    logic        ready;
    logic        busy;
    logic        we;
    logic [1:0]  ra1;
    logic [1:0]  ra2;
    logic [1:0]  wa;
    logic [2:0]  alu;
    logic [15:0] retired;
  } vec_t;

  logic        Clk;
  logic        Rst;
  logic        InstrValid;
  logic [9:0]  InstrData;
  logic        InstrReady;
  logic [1:0]  RegReadAddr1, RegReadAddr2, RegWriteAddr;
  logic        RegWriteEnable;
  logic [2:0]  ALUControl;
  logic        Busy;
  logic [15:0] RetiredCount;

  logic        w_rst;
  logic        w_valid;
  logic [9:0]  w_data;
  logic        w_ready;
  logic [1:0]  w_ra1, w_ra2, w_wa;
  logic        w_we;
  logic [2:0]  w_alu;
  logic        w_busy;
  logic [1:0]  w_retired;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  datapath_sequencer dut (
    .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .InstrData(InstrData),
    .InstrReady(InstrReady), .RegReadAddr1(RegReadAddr1), .RegReadAddr2(RegReadAddr2),
    .RegWriteAddr(RegWriteAddr), .RegWriteEnable(RegWriteEnable), .ALUControl(ALUControl),
    .Busy(Busy), .RetiredCount(RetiredCount)
  );

  datapath_sequencer #(.FIFO_DEPTH(2), .COUNT_WIDTH(2)) dut_wrap (
    .Clk(Clk), .Rst(w_rst), .InstrValid(w_valid), .InstrData(w_data),
    .InstrReady(w_ready), .RegReadAddr1(w_ra1), .RegReadAddr2(w_ra2),
    .RegWriteAddr(w_wa), .RegWriteEnable(w_we), .ALUControl(w_alu),
    .Busy(w_busy), .RetiredCount(w_retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic rst, input logic valid, input logic [9:0] data,
                              input logic chk, input logic ready, input logic busy,
                              input logic we, input logic [1:0] ra1, input logic [1:0] ra2,
                              input logic [1:0] wa, input logic [2:0] alu,
                              input logic [15:0] retired);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.chk = chk;
    v.ready = ready; v.busy = busy; v.we = we; v.ra1 = ra1; v.ra2 = ra2;
    v.wa = wa; v.alu = alu; v.retired = retired;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    Rst        = v.rst;
    InstrValid = v.valid;
    InstrData  = v.data;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [27:0] act, exp;
    act = {InstrReady, Busy, RegWriteEnable, RegReadAddr1, RegReadAddr2,
           RegWriteAddr, ALUControl, RetiredCount};
    exp = {v.ready, v.busy, v.we, v.ra1, v.ra2, v.wa, v.alu, v.retired};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL vec%0d {ready,busy,we,ra1,ra2,wa,alu,retired} got=%h expected=%h",
               idx, act, exp);
    end
  endtask

  initial begin
    int exp_wrap [5];
    int pulses;
    int waited;

    Rst = 1'b0; InstrValid = 1'b0; InstrData = '0;
    w_rst = 1'b0; w_valid = 1'b0; w_data = '0;

    //            rst valid data   chk rdy busy we ra1 ra2 wa alu ret
    vecs.push_back(mk(0, 1, 10'h006, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 10'h006, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // Single add R0 <- R1 + R2.
    vecs.push_back(mk(1, 1, 10'h006, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    // Back-to-back stream with valid held high; ready drops while full.
    vecs.push_back(mk(1, 1, 10'h006, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 10'h09B, 1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 10'h0F8, 1, 1, 1, 0, 1, 2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 10'h067, 1, 0, 1, 1, 1, 2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 10'h067, 1, 1, 1, 0, 2, 3, 1, 2, 2));
    vecs.push_back(mk(1, 0, 10'h000, 1, 0, 1, 1, 2, 3, 1, 2, 2));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 2, 0, 3, 3, 3));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 1, 2, 0, 3, 3, 3));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 3, 2, 1, 4));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 1, 1, 3, 2, 1, 4));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 5));
    // Nop still retires but never writes.
    vecs.push_back(mk(1, 1, 10'h206, 1, 1, 0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 2, 0, 0, 5));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 2, 0, 0, 5));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 6));
    // Reset asserted during WRITE of 067 with 006 still queued.
    vecs.push_back(mk(1, 1, 10'h067, 1, 1, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(1, 1, 10'h006, 1, 1, 1, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 3, 2, 1, 6));
    vecs.push_back(mk(0, 0, 10'h000, 1, 1, 1, 0, 1, 3, 2, 1, 6));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // Undefined ALU opcode 111 passes straight through.
    vecs.push_back(mk(1, 1, 10'h1C6, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 0, 1, 2, 0, 7, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 1, 1, 1, 2, 0, 7, 0));
    vecs.push_back(mk(1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      @(negedge Clk);
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].chk) checkOutput(i, vecs[i]);
    end

    // Counter wrap on the 2-bit instance: each instruction retires on its own.
    exp_wrap = '{1, 2, 3, 0, 1};
    @(negedge Clk);
    w_rst = 1'b0;
    @(negedge Clk);
    w_rst = 1'b1;
    #1;
    checks++;
    if (w_retired !== 2'd0 || w_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_reset retired=%0d busy=%0b expected retired=0 busy=0",
               w_retired, w_busy);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      w_valid = 1'b1;
      w_data  = (k % 2 == 0) ? 10'h0D9 : 10'h242;
      @(negedge Clk);
      w_valid = 1'b0;
      pulses = 0;
      waited = 0;
      while (w_busy && waited < 10) begin
        if (w_we) pulses++;
        @(negedge Clk);
        waited++;
      end
      checks++;
      if (w_busy) begin
        failures++;
        $display("[TB] FAIL wrap_timeout%0d busy=%0b expected busy=0 within 10 cycles", k, w_busy);
      end else if (w_retired !== 2'(exp_wrap[k])) begin
        failures++;
        $display("[TB] FAIL wrap_count%0d retired=%0d expected=%0d", k, w_retired, exp_wrap[k]);
      end
      checks++;
      if (pulses != ((k % 2 == 0) ? 1 : 0)) begin
        failures++;
        $display("[TB] FAIL wrap_we%0d pulses=%0d expected=%0d", k, pulses, (k % 2 == 0) ? 1 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
